// File: rtl/alu_entry_pkg.sv
// Shared types for the ALU command-entry front end: FSM state encoding
// (also shown on the state LEDs) and the ALU operation codes.
package alu_entry_pkg;

  // State encoding is visible on state_led, so the values are fixed.
  typedef enum logic [1:0] {
    S_A     = 2'b00,
    S_B     = 2'b01,
    S_OP    = 2'b10,
    S_ISSUE = 2'b11
  } state_t;

  localparam int SEL_W = 3;

  // Operation codes as the ALU decodes them.
  typedef enum logic [SEL_W-1:0] {
    SEL_ADD = 3'd0,
    SEL_SUB = 3'd1,
    SEL_AND = 3'd2,
    SEL_OR  = 3'd3,
    SEL_XOR = 3'd4,
    SEL_NOR = 3'd5,
    SEL_SLL = 3'd6,
    SEL_SRL = 3'd7
  } sel_t;

  // Step the operation code up or down with wrap-around. Both or neither
  // direction leaves the code unchanged.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                input logic up,
                                                input logic down);
    logic [SEL_W-1:0] res;
    res = sel;
    if (up && !down) begin
      res = (sel == SEL_SRL) ? SEL_ADD : sel + 3'd1;
    end else if (down && !up) begin
      res = (sel == SEL_ADD) ? SEL_SRL : sel - 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchronizer, counter-based debounce
// and a one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES cycles in a row;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_deb;
  assign press = r_deb & ~r_deb_d;

endmodule

// File: rtl/alu_cmd_entry.sv
// Board front end for the 4-bit ALU: conditions BTNL/BTNC/BTNR and walks the
// user through entering operand a, operand b and the operation code.
//
// Issue semantics: issue is a valid-only strobe with no ready. It is high
// for exactly one cycle (state S_ISSUE) and a/b/select are stable in that
// cycle and afterwards until the user overwrites them in a new round.
module alu_cmd_entry
  import alu_entry_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     sw,
  input  logic             btn_l,
  input  logic             btn_c,
  input  logic             btn_r,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [SEL_W-1:0] select,
  output logic             issue,
  output logic [1:0]       state_led
);

  logic             w_press_l;
  logic             w_press_c;
  logic             w_press_r;
  logic [2:0]       w_level;
  logic             w_unused_levels;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [SEL_W-1:0] r_sel;
  logic [W-1:0]     w_a_nxt;
  logic [W-1:0]     w_b_nxt;
  logic [SEL_W-1:0] w_sel_nxt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_l),
    .level (w_level[2]),
    .press (w_press_l)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_c),
    .level (w_level[1]),
    .press (w_press_c)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_r),
    .level (w_level[0]),
    .press (w_press_r)
  );

  // Entry only reacts to press pulses; the held levels are not needed here.
  assign w_unused_levels = ^w_level;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next operand/select values; everything holds by default.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sel_nxt   = r_sel;
    case (r_state)
      S_A: begin
        if (w_press_c) begin
          w_a_nxt     = sw;
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        if (w_press_c) begin
          w_b_nxt     = sw;
          w_state_nxt = S_OP;
        end else if (w_press_l) begin
          w_state_nxt = S_A;
        end
      end
      S_OP: begin
        // Confirm wins over any simultaneous select change.
        if (w_press_c) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_sel_nxt = sel_step(r_sel, w_press_r, w_press_l);
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_A;
      end
      default: begin
        w_state_nxt = S_A;
      end
    endcase
  end

  // Operand and operation-code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= '0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_sel <= w_sel_nxt;
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign select    = r_sel;
  assign issue     = (r_state == S_ISSUE);
  assign state_led = r_state;

endmodule

// File: tb/tb_alu_cmd_entry.sv
// Directed bench for alu_cmd_entry with DEB_CYCLES=4: reset, bounce
// rejection, then a table of button presses with expected results.
module tb_alu_cmd_entry;

  localparam int DEB = 4;
  localparam int W   = 4;
  localparam logic [2:0] B_NONE = 3'b000;
  localparam logic [2:0] B_L    = 3'b100;
  localparam logic [2:0] B_C    = 3'b010;
  localparam logic [2:0] B_R    = 3'b001;

  typedef struct {
    logic [2:0]   btn;   // {l, c, r}
    logic [W-1:0] sw;
    logic [1:0]   st;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         iss;   // this press completes a command
  } vec_t;

  // Clock/reset block
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_l = 1'b0;
  logic         btn_c = 1'b0;
  logic         btn_r = 1'b0;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   select;
  logic         issue;
  logic [1:0]   state_led;

  always #5 clk = ~clk;

  alu_cmd_entry #(.DEB_CYCLES(DEB), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_l     (btn_l),
    .btn_c     (btn_c),
    .btn_r     (btn_r),
    .a         (a),
    .b         (b),
    .select    (select),
    .issue     (issue),
    .state_led (state_led)
  );

  // Scoreboard: expected issued commands {state, a, b, select}
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  int          dbl_cnt = 0;
  logic        prev_issue = 1'b0;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[24];

  // Record every issue pulse and any back-to-back pulse.
  always @(negedge clk) begin
    if (issue === 1'b1) begin
      got_q.push_back({state_led, a, b, select});
      if (prev_issue) dbl_cnt = dbl_cnt + 1;
    end
    prev_issue = (issue === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Driver: hold the given buttons long enough to be accepted, then release
  // and wait until the release has settled.
  task automatic press(input logic [2:0] btn, input logic [W-1:0] swv);
    @(posedge clk);
    #1;
    sw    = swv;
    btn_l = btn[2];
    btn_c = btn[1];
    btn_r = btn[0];
    repeat (10) @(posedge clk);
    #1;
    btn_l = 1'b0;
    btn_c = 1'b0;
    btn_r = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] btn, input logic [W-1:0] swv,
                              input logic [1:0] st, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic [2:0] sel,
                              input logic iss);
    vec_t v;
    v.btn = btn; v.sw = swv; v.st = st; v.a = av; v.b = bv; v.sel = sel; v.iss = iss;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [1:0] st, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic [2:0] sel);
    chk({tag, "_state"}, 32'(state_led), 32'(st));
    chk({tag, "_a"}, 32'(a), 32'(av));
    chk({tag, "_b"}, 32'(b), 32'(bv));
    chk({tag, "_sel"}, 32'(select), 32'(sel));
  endtask

  initial begin
    // Full entry, increments, issue
    vecs[0]  = mk(B_C,       4'h3, 2'b01, 4'h3, 4'h0, 3'd0, 1'b0);
    vecs[1]  = mk(B_C,       4'hA, 2'b10, 4'h3, 4'hA, 3'd0, 1'b0);
    vecs[2]  = mk(B_R,       4'hF, 2'b10, 4'h3, 4'hA, 3'd1, 1'b0);
    vecs[3]  = mk(B_R,       4'hF, 2'b10, 4'h3, 4'hA, 3'd2, 1'b0);
    vecs[4]  = mk(B_R,       4'hF, 2'b10, 4'h3, 4'hA, 3'd3, 1'b0);
    vecs[5]  = mk(B_C,       4'hF, 2'b00, 4'h3, 4'hA, 3'd3, 1'b1);
    // Second round: walk select down through the wrap and back
    vecs[6]  = mk(B_C,       4'h1, 2'b01, 4'h1, 4'hA, 3'd3, 1'b0);
    vecs[7]  = mk(B_C,       4'h2, 2'b10, 4'h1, 4'h2, 3'd3, 1'b0);
    vecs[8]  = mk(B_L,       4'hF, 2'b10, 4'h1, 4'h2, 3'd2, 1'b0);
    vecs[9]  = mk(B_L,       4'hF, 2'b10, 4'h1, 4'h2, 3'd1, 1'b0);
    vecs[10] = mk(B_L,       4'hF, 2'b10, 4'h1, 4'h2, 3'd0, 1'b0);
    vecs[11] = mk(B_L,       4'hF, 2'b10, 4'h1, 4'h2, 3'd7, 1'b0);
    vecs[12] = mk(B_R,       4'hF, 2'b10, 4'h1, 4'h2, 3'd0, 1'b0);
    vecs[13] = mk(B_L | B_R, 4'hF, 2'b10, 4'h1, 4'h2, 3'd0, 1'b0);
    vecs[14] = mk(B_R,       4'hF, 2'b10, 4'h1, 4'h2, 3'd1, 1'b0);
    vecs[15] = mk(B_C | B_R, 4'hF, 2'b00, 4'h1, 4'h2, 3'd1, 1'b1);
    // Back navigation from S_B, ignored buttons
    vecs[16] = mk(B_C,       4'h6, 2'b01, 4'h6, 4'h2, 3'd1, 1'b0);
    vecs[17] = mk(B_L,       4'hF, 2'b00, 4'h6, 4'h2, 3'd1, 1'b0);
    vecs[18] = mk(B_C,       4'h5, 2'b01, 4'h5, 4'h2, 3'd1, 1'b0);
    vecs[19] = mk(B_R,       4'hF, 2'b01, 4'h5, 4'h2, 3'd1, 1'b0);
    vecs[20] = mk(B_C,       4'h9, 2'b10, 4'h5, 4'h9, 3'd1, 1'b0);
    vecs[21] = mk(B_C,       4'hF, 2'b00, 4'h5, 4'h9, 3'd1, 1'b1);
    vecs[22] = mk(B_L,       4'hF, 2'b00, 4'h5, 4'h9, 3'd1, 1'b0);
    vecs[23] = mk(B_R,       4'hF, 2'b00, 4'h5, 4'h9, 3'd1, 1'b0);

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por", 2'b00, 4'h0, 4'h0, 3'd0);
    chk("por_issue", 32'(issue), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-entry with buttons held: asynchronous clear
    press(B_C, 4'h7);
    check_outputs("pre_rst", 2'b01, 4'h7, 4'h0, 3'd0);
    @(posedge clk);
    #1;
    btn_l = 1'b1; btn_c = 1'b1; btn_r = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_outputs("async_rst", 2'b00, 4'h0, 4'h0, 3'd0);
    chk("async_rst_issue", 32'(issue), 32'd0);
    sw = 4'hC;
    @(posedge clk);
    #1 rst = 1'b0;
    // Held buttons must be re-qualified from scratch before any effect.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_requal_wait_state", 32'(state_led), 32'd0);
    chk("rst_requal_wait_a", 32'(a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_requal_state", 32'(state_led), 32'd1);
    chk("rst_requal_a", 32'(a), 32'hC);
    btn_l = 1'b0; btn_c = 1'b0; btn_r = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Clean reset before the functional sequences
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Bounce rejection: C toggles every 2 cycles, then stays low
    sw = 4'h8;
    for (int i = 0; i < 5; i++) begin
      btn_c = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      btn_c = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("bounce_state", 32'(state_led), 32'd0);
    chk("bounce_a", 32'(a), 32'd0);
    chk("pre_table_issues", 32'(got_q.size()), 32'd0);
    got_q.delete();

    // Table-driven entries
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].iss) exp_q.push_back({2'b11, vecs[i].a, vecs[i].b, vecs[i].sel});
      press(vecs[i].btn, vecs[i].sw);
      check_outputs($sformatf("v%0d", i), vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].sel);
      chk($sformatf("v%0d_issue_count", i), 32'(got_q.size()), vecs[i].iss ? 32'd1 : 32'd0);
      if (vecs[i].iss && got_q.size() > 0 && exp_q.size() > 0) begin
        chk($sformatf("v%0d_issue_cmd", i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      end
      got_q.delete();
    end
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("no_double_issue", 32'(dbl_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_entry.md
Name: alu_cmd_entry

Overview:
Operand/command front end for the 4-bit ALU on the board. It takes raw push-buttons (BTNL, BTNC, BTNR) and the 4 operand switches, then debounces and edge-detects the buttons. A small FSM steps the user through entering operand a, operand b and the operation code. When the entry is complete, it presents stable a, b and select to the ALU with a one-cycle issue strobe. It sits between the board I/O pins and the ALU instance in the board top level.

Parameters:
DEB_CYCLES, 16, consecutive synchronized cycles a button level must hold before it is accepted (board build overrides with about 1_000_000; must be at least 2).
W, 4, operand width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sw  in  W  operand switches, sampled on capture (treated as quasi-static)
btn_l  in  1  raw BTNL: back in operand states; decrement select in S_OP
btn_c  in  1  raw BTNC: confirm/advance
btn_r  in  1  raw BTNR: increment select in S_OP
a  out  W  latched operand a to ALU
b  out  W  latched operand b to ALU
select  out  3  latched ALU operation code
issue  out  1  one-cycle strobe: a/b/select form a new complete command
state_led  out  2  current FSM state encoding for LEDs

Behaviour:
Reset (async, rst=1):
- a=0, b=0, select=0, issue=0, state=S_A (state_led=00).
- All synchronizer flops, debounced levels and counters are cleared to 0.
- Reset mid-bounce or mid-entry discards all progress.

Per-button conditioning (identical for all three buttons):
- 2-flop synchronizer produces s (raw delayed 2 edges).
- Debounced level deb with counter cnt:
  - s==deb: cnt<=0.
  - s!=deb and cnt==DEB_CYCLES-1: deb<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- A glitch shorter than DEB_CYCLES synchronized cycles never changes deb.
- press = deb & ~deb_d (deb_d is deb delayed one cycle). It is a one-cycle pulse on an accepted rising level only. Release generates nothing.
- Latency: raw high from before edge k (and held) gives deb=1 after edge k+1+DEB_CYCLES and press high in the following cycle. The FSM effect is visible on outputs after edge k+2+DEB_CYCLES.

FSM states (registered outputs; all actions occur on the edge where press is high):
- S_A (00):
  - press_c: a<=sw, go S_B.
  - press_l and press_r are ignored.
- S_B (01):
  - press_c: b<=sw, go S_OP.
  - press_l: go S_A, with a unchanged.
  - press_r is ignored.
- S_OP (10):
  - press_r: select<=select+1, wrapping 7 to 0.
  - press_l: select<=select-1, wrapping 0 to 7.
  - press_l and press_r in the same cycle: select unchanged.
  - press_c: go S_ISSUE. press_c takes priority over l/r, so select is unchanged in that cycle.
- S_ISSUE (11):
  - issue=1 for exactly this one cycle.
  - Next state is S_A unconditionally. Button presses in this cycle are ignored.

Hold and timing rules:
- a, b and select hold their values across states and new entry rounds until explicitly overwritten.
- issue is 0 in every state except S_ISSUE.
- issue never asserts twice without a full S_A → S_B → S_OP traversal in between.

Decomposition:
- Shared package alu_entry_pkg:
  - state typedef (S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_ISSUE=2'b11).
  - select code constants matching the ALU operation encoding (0..7).
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst, raw, level, press), instantiated three times.
- The FSM and operand registers stay in alu_cmd_entry.

Test Plan:
All scenarios use DEB_CYCLES=4.
1. Reset: assert rst mid-cycle with buttons high → a=0, b=0, select=0, issue=0, state_led=00 immediately (asynchronous), and no press after release of rst until buttons are re-accepted.
2. Bounce rejection: btn_c toggles every 2 cycles for 20 cycles, then held low → state_led stays 00 and a stays 0.
3. Full entry: sw=4'h3, press C; sw=4'hA, press C; press R three times; press C → exactly one issue pulse. In that cycle a=3, b=A, select=3, then state_led=00.
4. Wrap: in S_OP with select=0, press L → select=7; press R → select=0.
5. Back navigation: in S_B, press L → state_led=00 and a unchanged. Press C with sw=5 → a=5.
6. Simultaneous: in S_OP, btn_l and btn_r rise on the same edge → select unchanged. btn_c and btn_r rise together → state goes to S_ISSUE with select unchanged.
